// File: rtl/gain_scheduler.sv
// rtl/gain_scheduler.sv - round-robin shared quarter-step gain multiplier with per-channel ramping
module gain_scheduler #(
  parameter int N_CH     = 4,
  parameter int DW       = 24,
  parameter int RAMP_DIV = 16,
  parameter int GAIN_RST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [3:0]        cfg_gain,
  input  logic              cfg_jump,
  output logic [DW-1:0]     out_data,
  output logic [2:0]        out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_CH-1:0]   ramp_busy
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);
  localparam logic [3:0] G_RST = 4'(GAIN_RST);
  localparam int PW = DW + 5;
  localparam logic signed [PW-1:0] SAT_MAX = {6'b000000, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {6'b111111, {(DW-1){1'b0}}};

  logic [3:0]    cur_gain_q [N_CH];
  logic [3:0]    cur_gain_d [N_CH];
  logic [3:0]    tgt_gain_q [N_CH];
  logic [3:0]    tgt_gain_d [N_CH];
  logic [CW-1:0] cnt_q [N_CH];
  logic [CW-1:0] cnt_d [N_CH];
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [2:0]    s1_ch_q, s1_ch_d;
  logic [3:0]    s1_gain_q, s1_gain_d;
  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic [2:0]    s2_ch_q, s2_ch_d;

  logic [2*N_CH-1:0] rot_valid;
  logic [2:0]        off;
  logic [3:0]        gnt_sum;
  logic [2:0]        gnt_idx;
  logic [N_CH-1:0]   grant;
  logic              acc, s2_adv, s1_take;
  logic [DW-1:0]     sel_data;
  logic [3:0]        sel_gain, cfg_clamp;
  logic signed [PW-1:0] prod, prod_sh;
  logic [DW-1:0]     sat;

  // Rotate the request vector so the pointer channel sits at bit 0, then take the first set bit.
  always_comb begin
    rot_valid = {in_valid, in_valid} >> rr_ptr_q;
    off = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (rot_valid[j]) off = 3'(j);
    end
    gnt_sum = {1'b0, rr_ptr_q} + {1'b0, off};
    gnt_idx = (gnt_sum >= 4'(N_CH)) ? 3'(gnt_sum - 4'(N_CH)) : gnt_sum[2:0];
    grant   = (|in_valid) ? (N_CH'(1) << gnt_idx) : '0;
    s2_adv  = !s2_valid_q || out_ready;
    s1_take = !s1_valid_q || s2_adv;
    in_ready = rst ? '0 : (grant & {N_CH{s1_take}});
    acc      = |(in_valid & in_ready);
    sel_data = '0;
    sel_gain = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*DW +: DW];
        sel_gain = cur_gain_q[i];
      end
    end
  end

  always_comb begin
    prod    = $signed({{5{s1_data_q[DW-1]}}, s1_data_q}) * $signed({{(PW-4){1'b0}}, s1_gain_q});
    prod_sh = prod >>> 2;
    if (prod_sh > SAT_MAX)      sat = SAT_MAX[DW-1:0];
    else if (prod_sh < SAT_MIN) sat = SAT_MIN[DW-1:0];
    else                        sat = prod_sh[DW-1:0];
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_ch_d    = s1_ch_q;
    s1_gain_d  = s1_gain_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ch_d    = s2_ch_q;
    cfg_clamp  = (cfg_gain > 4'd10) ? 4'd10 : cfg_gain;
    if (acc) rr_ptr_d = (gnt_idx == 3'(N_CH - 1)) ? 3'd0 : gnt_idx + 3'd1;
    if (s1_take) begin
      s1_valid_d = acc;
      if (acc) begin
        s1_data_d = sel_data;
        s1_ch_d   = gnt_idx;
        s1_gain_d = sel_gain;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = sat;
        s2_ch_d   = s1_ch_q;
      end
    end
    // The ramp step compares against the old target; a same-cycle write then overrides.
    for (int i = 0; i < N_CH; i++) begin
      cur_gain_d[i] = cur_gain_q[i];
      tgt_gain_d[i] = tgt_gain_q[i];
      cnt_d[i]      = cnt_q[i];
      if (acc && gnt_idx == 3'(i)) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i] = '0;
          if (cur_gain_q[i] < tgt_gain_q[i])      cur_gain_d[i] = cur_gain_q[i] + 4'd1;
          else if (cur_gain_q[i] > tgt_gain_q[i]) cur_gain_d[i] = cur_gain_q[i] - 4'd1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      if (cfg_we && cfg_ch == 3'(i)) begin
        tgt_gain_d[i] = cfg_clamp;
        if (cfg_jump) begin
          cur_gain_d[i] = cfg_clamp;
          cnt_d[i]      = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cur_gain_q[i] <= G_RST;
        tgt_gain_q[i] <= G_RST;
        cnt_q[i]      <= '0;
      end
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_ch_q    <= '0;
      s1_gain_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ch_q    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cur_gain_q[i] <= cur_gain_d[i];
        tgt_gain_q[i] <= tgt_gain_d[i];
        cnt_q[i]      <= cnt_d[i];
      end
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_ch_q    <= s1_ch_d;
      s1_gain_q  <= s1_gain_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ch_q    <= s2_ch_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) ramp_busy[i] = (cur_gain_q[i] != tgt_gain_q[i]);
  end

  assign out_data  = s2_data_q;
  assign out_ch    = s2_ch_q;
  assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_gain_scheduler.sv
// tb/tb_gain_scheduler.sv - directed self-checking bench for gain_scheduler
module tb_gain_scheduler;
  localparam int N_CH = 4;
  localparam int DW   = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic [3:0]        cfg_gain;
  logic              cfg_jump;
  logic [DW-1:0]     out_data;
  logic [2:0]        out_ch;
  logic              out_valid;
  logic              out_ready;
  logic [N_CH-1:0]   ramp_busy;

  int checks = 0;
  int failures = 0;

  gain_scheduler #(.N_CH(N_CH), .DW(DW), .RAMP_DIV(2), .GAIN_RST(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain), .cfg_jump(cfg_jump),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .ramp_busy(ramp_busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = '0; in_data = '0; cfg_we = 1'b0; cfg_jump = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [3:0] g, input logic j);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_gain = g; cfg_jump = j;
    @(negedge clk);
    cfg_we = 1'b0; cfg_jump = 1'b0;
  endtask

  // One sample on one channel into an empty pipeline; returns what appears two edges later.
  task automatic xfer(input int ch, input logic [DW-1:0] d,
                      output logic [DW-1:0] od, output logic [2:0] oc, output logic ov);
    @(negedge clk);
    in_data = '0;
    in_data[ch*DW +: DW] = d;
    in_valid = N_CH'(1) << ch;
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    od = out_data; oc = out_ch; ov = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; in_data = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_gain = '0;
    cfg_jump = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL reset_out_ch got %0h exp 0", out_ch); end
    checks++; if (ramp_busy !== '0) begin failures++; $display("FAIL reset_ramp_busy got %0h exp 0", ramp_busy); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (in_ready !== '0) begin failures++; $display("FAIL idle_in_ready got %0h exp 0", in_ready); end
  endtask

  task automatic test_unity_latency();
    @(negedge clk);
    in_data = '0; in_data[0 +: DW] = 24'd1000; in_valid = 4'b0001;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL t1_in_ready got %0h exp 1", in_ready); end
    @(negedge clk);
    in_valid = '0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_early_valid got %0h exp 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t1_out_valid got %0h exp 1", out_valid); end
    checks++; if (out_data !== 24'd1000) begin failures++; $display("FAIL t1_out_data got %0d exp 1000", out_data); end
    checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL t1_out_ch got %0d exp 0", out_ch); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_drop got %0h exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        for (int i = 0; i < N_CH; i++) in_data[i*DW +: DW] = 24'((i + 1) * 100);
        in_valid = 4'hF;
      end
      #1;
      checks++;
      if (in_ready !== 4'(1 << (k % 4))) begin
        failures++; $display("FAIL rr_grant[%0d] got %0h exp %0h", k, in_ready, 4'(1 << (k % 4)));
      end
      if (k >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 3'((k - 2) % 4) || out_data !== 24'((((k - 2) % 4) + 1) * 100)) begin
          failures++;
          $display("FAIL rr_out[%0d] got v=%0h ch=%0d d=%0d exp v=1 ch=%0d d=%0d", k, out_valid, out_ch,
                   out_data, (k - 2) % 4, (((k - 2) % 4) + 1) * 100);
        end
      end
    end
    @(negedge clk);
    in_valid = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [DW-1:0] od; logic [2:0] oc; logic ov;
    do_reset();
    cfg_write(3'd1, 4'd10, 1'b1);
    checks++; if (ramp_busy !== '0) begin failures++; $display("FAIL sat_jump_busy got %0h exp 0", ramp_busy); end
    xfer(1, 24'h3FFFFF, od, oc, ov);
    checks++;
    if (ov !== 1'b1 || oc !== 3'd1 || od !== 24'h7FFFFF) begin
      failures++; $display("FAIL sat_pos got v=%0h ch=%0d d=%0h exp v=1 ch=1 d=7fffff", ov, oc, od);
    end
    xfer(1, 24'hC00000, od, oc, ov);
    checks++;
    if (ov !== 1'b1 || od !== 24'h800000) begin
      failures++; $display("FAIL sat_neg got v=%0h d=%0h exp v=1 d=800000", ov, od);
    end
    xfer(1, 24'd100, od, oc, ov);
    checks++; if (od !== 24'd250) begin failures++; $display("FAIL gain10_mid got %0d exp 250", od); end
  endtask

  task automatic test_ramp();
    logic [DW-1:0] od; logic [2:0] oc; logic ov;
    logic [DW-1:0] exp_v [6];
    exp_v[0] = 24'd400; exp_v[1] = 24'd400; exp_v[2] = 24'd500;
    exp_v[3] = 24'd500; exp_v[4] = 24'd600; exp_v[5] = 24'd600;
    do_reset();
    cfg_write(3'd0, 4'd6, 1'b0);
    checks++; if (ramp_busy !== 4'b0001) begin failures++; $display("FAIL ramp_busy_set got %0h exp 1", ramp_busy); end
    for (int n = 0; n < 6; n++) begin
      xfer(0, 24'd400, od, oc, ov);
      checks++;
      if (ov !== 1'b1 || od !== exp_v[n]) begin
        failures++; $display("FAIL ramp_out[%0d] got v=%0h d=%0d exp v=1 d=%0d", n, ov, od, exp_v[n]);
      end
      if (n == 2) begin
        checks++; if (ramp_busy[0] !== 1'b1) begin failures++; $display("FAIL ramp_busy_3rd got %0h exp 1", ramp_busy[0]); end
      end
      if (n == 3) begin
        checks++; if (ramp_busy[0] !== 1'b0) begin failures++; $display("FAIL ramp_busy_4th got %0h exp 0", ramp_busy[0]); end
      end
    end
  endtask

  task automatic test_stall();
    int next_val, exp_out;
    logic [DW-1:0] held;
    do_reset();
    next_val = 1; exp_out = 1; held = '0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 11);
      in_valid  = (cyc < 15) ? 4'b0100 : 4'b0000;
      in_data[2*DW +: DW] = 24'(next_val);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 24'(exp_out) || out_ch !== 3'd2) begin
          failures++; $display("FAIL stall_seq got ch=%0d d=%0d exp ch=2 d=%0d", out_ch, out_data, exp_out);
        end
        exp_out++;
      end
      if (cyc == 6) held = out_data;
      if (cyc > 6 && cyc < 11) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          failures++; $display("FAIL stall_hold[%0d] got v=%0h d=%0d exp v=1 d=%0d", cyc, out_valid, out_data, held);
        end
      end
      if (cyc >= 6 && cyc < 11) begin
        checks++;
        if (in_ready !== '0) begin failures++; $display("FAIL stall_in_ready[%0d] got %0h exp 0", cyc, in_ready); end
      end
      if (in_valid[2] && in_ready[2]) next_val++;
    end
    checks++;
    if (exp_out !== next_val || next_val < 10) begin
      failures++; $display("FAIL stall_count got recv=%0d exp sent=%0d", exp_out - 1, next_val - 1);
    end
  endtask

  task automatic test_cfg_and_reset();
    logic [DW-1:0] od; logic [2:0] oc; logic ov;
    int seen;
    do_reset();
    cfg_write(3'd3, 4'd15, 1'b1);
    xfer(3, 24'd100, od, oc, ov);
    checks++;
    if (ov !== 1'b1 || oc !== 3'd3 || od !== 24'd250) begin
      failures++; $display("FAIL clamp_gain got v=%0h ch=%0d d=%0d exp v=1 ch=3 d=250", ov, oc, od);
    end
    cfg_write(3'd7, 4'd0, 1'b0);
    checks++; if (ramp_busy !== '0) begin failures++; $display("FAIL bad_ch_busy got %0h exp 0", ramp_busy); end
    xfer(3, 24'd100, od, oc, ov);
    checks++; if (od !== 24'd250) begin failures++; $display("FAIL bad_ch_gain3 got %0d exp 250", od); end
    xfer(0, 24'd1000, od, oc, ov);
    checks++; if (od !== 24'd1000) begin failures++; $display("FAIL bad_ch_gain0 got %0d exp 1000", od); end
    cfg_write(3'd1, 4'd8, 1'b0);
    checks++; if (ramp_busy !== 4'b0010) begin failures++; $display("FAIL pre_rst_busy got %0h exp 2", ramp_busy); end
    @(negedge clk);
    in_data = '0; in_data[0 +: DW] = 24'd77; in_valid = 4'b0001;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== 3'd0 || in_ready !== '0 || ramp_busy !== '0) begin
      failures++;
      $display("FAIL mid_rst got v=%0h d=%0h ch=%0d rdy=%0h busy=%0h exp all 0", out_valid, out_data, out_ch,
               in_ready, ramp_busy);
    end
    @(negedge clk);
    in_valid = '0;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL post_rst_output got %0d exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_unity_latency();
    test_back_to_back();
    test_saturation();
    test_ramp();
    test_stall();
    test_cfg_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
